sram_32_16_host: RTL and testbench

SRAM_32_16_HOST -- requirements
Module: sram_32_16_host

---
 rtl/sram_32_16_host.sv | 151 +++++++++++++++
 tb/tb_sram_32_16_host.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_32_16_host.sv
// sram_32_16_host: valid/ready host front end for a single-port synchronous SRAM, zero-filling the array after reset.
// Optional macro SRAM_HOST_WRITE_ACK_EN: writes also return a response carrying zero data.
module sram_32_16_host #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  init_done
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_we;
    logic                  r_csb0;
    logic                  r_web0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_init_done;

    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign init_done = r_init_done;

    // Controller FSM: every SRAM pin and handshake output is a flop, so req_* never reaches the macro combinationally.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_state     <= S_INIT;
            r_init_cnt  <= {ADDR_WIDTH{1'b0}};
            r_we        <= 1'b0;
            r_csb0      <= 1'b1;
            r_web0      <= 1'b1;
            r_addr0     <= {ADDR_WIDTH{1'b0}};
            r_din0      <= {DATA_WIDTH{1'b0}};
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // The last fill write is on the pins once csb0 is low with the top address.
                    if (!r_csb0 && (r_addr0 == ADDR_LAST)) begin
                        r_csb0      <= 1'b1;
                        r_web0      <= 1'b1;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_csb0  <= 1'b0;
                        r_web0  <= 1'b0;
                        r_din0  <= {DATA_WIDTH{1'b0}};
                        r_addr0 <= r_init_cnt;
                        if (r_init_cnt != ADDR_LAST) begin
                            r_init_cnt <= r_init_cnt + 1'b1;
                        end else begin
                            r_init_cnt <= r_init_cnt;
                        end
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_csb0      <= 1'b0;
                        r_web0      <= ~req_we;
                        r_addr0     <= req_addr;
                        r_we        <= req_we;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                        if (req_we) begin
                            r_din0 <= req_wdata;
                        end else begin
                            r_din0 <= r_din0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_csb0  <= 1'b1;
                    r_web0  <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!r_we) begin
                        r_rsp_rdata <= dout0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
`ifdef SRAM_HOST_WRITE_ACK_EN
                        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
`else
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_csb0      <= 1'b1;
                    r_web0      <= 1'b1;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_init_cnt  <= {ADDR_WIDTH{1'b0}};
                    r_state     <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_32_16_host.sv
// Directed bench for sram_32_16_host with a behavioural synchronous SRAM model on the port-0 pins.
module tb_sram_32_16_host;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk0 = 1'b0;
    logic          rst0_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = '0;
    logic          init_done;

    int n_tests = 0;
    int n_fail  = 0;

    sram_32_16_host #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .init_done(init_done)
    );

    always #5 clk0 = ~clk0;

    // Single-port SRAM: inputs sampled on the rising edge, read data appears after that edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0 <= mem[addr0];
        end
    end

`ifdef SRAM_HOST_WRITE_ACK_EN
    localparam logic WR_ACK = 1'b1;
`else
    localparam logic WR_ACK = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];
    time  acc_t [10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_csb0"}, {31'd0, csb0}, 32'd1);
        check({tag, "_web0"}, {31'd0, web0}, 32'd1);
        check({tag, "_addr0"}, {28'd0, addr0}, 32'd0);
        check({tag, "_din0"}, din0, 32'd0);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    endtask

    // Called at a falling edge just after reset release.
    task automatic run_init(input string tag);
        int wcount = 0;
        int bad = 0;
        for (int c = 0; c < 40 && !init_done; c++) begin
            @(negedge clk0);
            if (!csb0) begin
                if (web0 !== 1'b0 || addr0 !== wcount[AW-1:0] || din0 !== 32'd0 || req_ready !== 1'b0) bad++;
                wcount++;
            end else if (!init_done) begin
                bad++;
            end
        end
        check({tag, "_init_writes"}, wcount, 32'd16);
        check({tag, "_init_seq"}, bad, 32'd0);
        check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        check({tag, "_ready_after_init"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_csb0_after_init"}, {31'd0, csb0}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge clk0);
            w++;
        end
        if (w >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got req_ready=%b after %0d cycles expected 1", tag, req_ready, w);
        end
    endtask

    // One request with rsp_ready held high; checks pins at k, k+1 and the response at k+2.
    task automatic txn(input vec_t v, input string tag, output time t_acc);
        logic exp_rsp;
        exp_rsp = v.we ? WR_ACK : 1'b1;
        wait_ready(tag);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
        @(posedge clk0);
        t_acc = $time;
        @(negedge clk0);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        check({tag, "_k_csb0"}, {31'd0, csb0}, 32'd0);
        check({tag, "_k_web0"}, {31'd0, web0}, {31'd0, ~v.we});
        check({tag, "_k_addr0"}, {28'd0, addr0}, {28'd0, v.addr});
        check({tag, "_k_ready"}, {31'd0, req_ready}, 32'd0);
        if (v.we) check({tag, "_k_din0"}, din0, v.wdata);
        @(negedge clk0);
        check({tag, "_k1_csb0"}, {31'd0, csb0}, 32'd1);
        check({tag, "_k1_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk0);
        check({tag, "_k2_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, exp_rsp});
        if (exp_rsp) begin
            check({tag, "_k2_rdata"}, rsp_rdata, v.we ? 32'd0 : v.exp_rdata);
            check({tag, "_k2_ready"}, {31'd0, req_ready}, 32'd0);
            @(negedge clk0);
            check({tag, "_k3_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
            check({tag, "_k3_ready"}, {31'd0, req_ready}, 32'd1);
        end else begin
            check({tag, "_k2_ready"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        time   t_dummy;
        logic [DW-1:0] held;
        int    bad;
        vec_t  v;

        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hA5A5_0000 | i;

        vecs[0] = '{1'b0, 4'd7,  32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[2] = '{1'b0, 4'd3,  32'h0000_0000, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 4'd0,  32'h1234_5678, 32'h0000_0000};
        vecs[4] = '{1'b1, 4'd15, 32'h9ABC_DEF0, 32'h0000_0000};
        vecs[5] = '{1'b0, 4'd0,  32'h0000_0000, 32'h1234_5678};
        vecs[6] = '{1'b0, 4'd15, 32'h0000_0000, 32'h9ABC_DEF0};
        vecs[7] = '{1'b1, 4'd5,  32'h55AA_55AA, 32'h0000_0000};
        vecs[8] = '{1'b0, 4'd5,  32'h0000_0000, 32'h55AA_55AA};
        vecs[9] = '{1'b0, 4'd3,  32'h0000_0000, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk0);
        check_reset_values("rst");
        rst0_n = 1'b1;
        run_init("init1");

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i), acc_t[i]);
        end
        check("b2b_write_spacing", 32'(acc_t[4] - acc_t[3]), WR_ACK ? 32'd40 : 32'd30);

        // Stalled read of the top address while junk requests toggle.
        wait_ready("stall");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd15; rsp_ready = 1'b0;
        @(posedge clk0);
        @(negedge clk0);
        req_valid = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_rdata", rsp_rdata, 32'h9ABC_DEF0);
        held = rsp_rdata;
        bad = 0;
        req_we = 1'b1; req_addr = 4'd2; req_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            req_valid = ~req_valid;
            @(negedge clk0);
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || csb0 !== 1'b1 || addr0 !== 4'd15) bad++;
        end
        check("stall_hold", bad, 32'd0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk0);
        check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);
        v = '{1'b0, 4'd2, 32'h0, 32'h0};
        txn(v, "ignored_write", t_dummy);

        // Reset while a read is in WAIT.
        wait_ready("rstwait");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; rsp_ready = 1'b1;
        @(posedge clk0);
        @(negedge clk0);
        req_valid = 1'b0;
        @(negedge clk0);
        rst0_n = 1'b0;
        #1;
        check_reset_values("rst_wait");
        @(negedge clk0);
        check("rst_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
        rst0_n = 1'b1;
        run_init("init2");
        v = '{1'b0, 4'd3, 32'h0, 32'h0};
        txn(v, "post_rst_addr3", t_dummy);
        v = '{1'b0, 4'd15, 32'h0, 32'h0};
        txn(v, "post_rst_addr15", t_dummy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
